// File: rtl/conv_pkg.sv
// Shared types and helpers for the picture-memory read/write controllers.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } wr_state_t;

  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  // Kernel normalisation: arithmetic shift keeps the sign of the result.
  function automatic logic signed [31:0] pix_convert(
    input logic signed [31:0] din,
    input int                 shift
  );
    return din >>> shift;
  endfunction

endpackage

// File: rtl/pic_write_controller_if.sv
// CPU-result input and picture-memory write port bundle.
interface pic_write_controller_if #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32
);
  logic                     START;
  logic signed [DATA_W-1:0] DATA_IN;
  logic                     VALID;
  logic                     READY;
  logic                     MEM_STB;
  logic [ADDR_W-1:0]        MEM_ADDR;
  logic [PIX_W-1:0]         MEM_WDATA;
  logic                     MEM_WE;
  logic [1:0]               STATE;
  logic                     DONE;

  modport master (
    output START, DATA_IN, VALID, MEM_STB,
    input  READY, MEM_ADDR, MEM_WDATA, MEM_WE, STATE, DONE
  );

  modport slave (
    input  START, DATA_IN, VALID, MEM_STB,
    output READY, MEM_ADDR, MEM_WDATA, MEM_WE, STATE, DONE
  );
endinterface

// File: rtl/pix_saturate.sv
// Shift a signed result down to one pixel.
// PIC_WR_CLAMP_EN selects clamping to [0, 2^PIX_W-1]; otherwise plain truncation.
module pix_saturate
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int SHIFT  = 4
) (
  input  logic signed [DATA_W-1:0] din,
  output logic [PIX_W-1:0]         pix
);

`ifdef PIC_WR_CLAMP_EN
  localparam logic signed [31:0] MAXV = (32'sd1 <<< PIX_W) - 32'sd1;

  logic signed [31:0] v;

  always_comb begin
    v = pix_convert(32'(din), SHIFT);
    if (v < 0)
      pix = '0;
    else if (v > MAXV)
      pix = '1;
    else
      pix = v[PIX_W-1:0];
  end
`else
  assign pix = PIX_W'(pix_convert(32'(din), SHIFT));
`endif

endmodule

// File: rtl/pic_write_controller.sv
// Writer side of the picture path: accept, convert, write one pixel per slot.
// Build option PIC_WR_CLAMP_EN enables pixel saturation in pix_saturate.
module pic_write_controller
  import conv_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                PIX_W     = 8,
  parameter int                ADDR_W    = 32,
  parameter int                IMG_W     = IMG_W_DEF,
  parameter int                IMG_H     = IMG_H_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                SHIFT     = 4
) (
  input logic                  CLK,
  input logic                  RST,
  pic_write_controller_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NPIX - 1);

  wr_state_t        state;
  logic [CNT_W-1:0] count;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] pix_next;

  pix_saturate #(
    .DATA_W(DATA_W),
    .PIX_W (PIX_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din(bus.DATA_IN),
    .pix(pix_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      count <= '0;
      pix_q <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            state <= S_ACCEPT;
            count <= '0;
          end
        end
        S_ACCEPT: begin
          if (bus.VALID) begin
            pix_q <= pix_next;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.MEM_STB) begin
            if (count == LAST) begin
              state <= S_DONE;
            end else begin
              count <= count + 1'b1;
              state <= S_ACCEPT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write strobe follows the slot strobe directly so a write lands in the offered slot.
  assign bus.MEM_WE    = (state == S_WRITE) & bus.MEM_STB;
  assign bus.READY     = (state == S_ACCEPT);
  assign bus.DONE      = (state == S_DONE);
  assign bus.STATE     = state;
  assign bus.MEM_WDATA = pix_q;
  assign bus.MEM_ADDR  = BASE_ADDR + ADDR_W'(count);

endmodule

// File: tb/tb_pic_write_controller.sv
// Directed bench for pic_write_controller on a 4x2 frame.
module tb_pic_write_controller;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  pic_write_controller_if #(
    .DATA_W(16), .PIX_W(8), .ADDR_W(32)
  ) bus ();

  pic_write_controller #(
    .DATA_W   (16),
    .PIX_W    (8),
    .ADDR_W   (32),
    .IMG_W    (4),
    .IMG_H    (2),
    .BASE_ADDR(BASE),
    .SHIFT    (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp_c;
    logic [7:0]  exp_t;
  } vec_t;

  int ncmp = 0;
  int nbad = 0;
  int nwr  = 0;

  always @(posedge CLK)
    if (bus.MEM_WE === 1'b1) nwr++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n = 0;
    while (bus.STATE !== s && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_state", 32'(bus.STATE), 32'(s));
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef PIC_WR_CLAMP_EN
    return v.exp_c;
`else
    return v.exp_t;
`endif
  endfunction

  task automatic pixel(input logic [15:0] din, input logic [7:0] exp,
                       input logic [31:0] addr);
    bus.DATA_IN = din;
    bus.VALID   = 1'b1;
    wait_state(2'd2);
    chk("wdata", 32'(bus.MEM_WDATA), 32'(exp));
    chk("addr", bus.MEM_ADDR, addr);
    chk("we", 32'(bus.MEM_WE), 32'(1));
    chk("ready_wr", 32'(bus.READY), 32'(0));
    @(negedge CLK);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h0FF0, 8'hFF, 8'hFF};
    vecs[1] = '{16'h1000, 8'hFF, 8'h00};
    vecs[2] = '{16'hFFE0, 8'h00, 8'hFE};
    vecs[3] = '{16'h0123, 8'h12, 8'h12};
    vecs[4] = '{16'h0A50, 8'hA5, 8'hA5};
    vecs[5] = '{16'h000F, 8'h00, 8'h00};
    vecs[6] = '{16'h1230, 8'hFF, 8'h23};
    vecs[7] = '{16'hFFEF, 8'h00, 8'hFE};

    RST         = 1'b1;
    bus.START   = 1'b0;
    bus.DATA_IN = '0;
    bus.VALID   = 1'b0;
    bus.MEM_STB = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_state", 32'(bus.STATE), 32'(0));
    chk("rst_ready", 32'(bus.READY), 32'(0));
    chk("rst_we", 32'(bus.MEM_WE), 32'(0));
    chk("rst_wdata", 32'(bus.MEM_WDATA), 32'(0));
    chk("rst_addr", bus.MEM_ADDR, BASE);
    chk("rst_done", 32'(bus.DONE), 32'(0));
    RST = 1'b0;

    @(negedge CLK);
    chk("idle_hold", 32'(bus.STATE), 32'(0));
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("start_state", 32'(bus.STATE), 32'(1));
    chk("start_ready", 32'(bus.READY), 32'(1));

    // Full frame, strobe and valid held high.
    bus.MEM_STB = 1'b1;
    for (int i = 0; i < 8; i++)
      pixel(vecs[i].din, pick(vecs[i]), BASE + 32'(i));

    chk("done", 32'(bus.DONE), 32'(1));
    chk("done_state", 32'(bus.STATE), 32'(3));
    chk("done_ready", 32'(bus.READY), 32'(0));
    chk("done_addr", bus.MEM_ADDR, BASE + 32'd7);
    chk("frame_writes", 32'(nwr), 32'd8);
    @(negedge CLK);
    chk("done_hold", 32'(bus.DONE), 32'(1));

    // Restart from DONE, then stall in S_WRITE.
    bus.MEM_STB = 1'b0;
    bus.START   = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("restart_state", 32'(bus.STATE), 32'(1));
    chk("restart_done", 32'(bus.DONE), 32'(0));
    chk("restart_addr", bus.MEM_ADDR, BASE);
    bus.DATA_IN = 16'h0A50;
    wait_state(2'd2);
    bus.START = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_state", 32'(bus.STATE), 32'(2));
      chk("stall_ready", 32'(bus.READY), 32'(0));
      chk("stall_we", 32'(bus.MEM_WE), 32'(0));
      chk("stall_wdata", 32'(bus.MEM_WDATA), 32'h0A5);
      @(negedge CLK);
    end
    bus.START   = 1'b0;
    bus.MEM_STB = 1'b1;
    #1;
    chk("stall_we_on", 32'(bus.MEM_WE), 32'(1));
    @(negedge CLK);
    chk("stall_next", 32'(bus.STATE), 32'(1));
    chk("stall_addr", bus.MEM_ADDR, BASE + 32'd1);
    chk("stall_writes", 32'(nwr), 32'd9);

    // Reach pixel 3 and reset while it waits for a slot.
    pixel(16'h0010, 8'h01, BASE + 32'd1);
    pixel(16'h0123, 8'h12, BASE + 32'd2);
    bus.MEM_STB = 1'b0;
    bus.DATA_IN = 16'h0FF0;
    wait_state(2'd2);
    chk("p3_addr", bus.MEM_ADDR, BASE + 32'd3);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_state", 32'(bus.STATE), 32'(0));
    chk("arst_we", 32'(bus.MEM_WE), 32'(0));
    chk("arst_wdata", 32'(bus.MEM_WDATA), 32'(0));
    chk("arst_addr", bus.MEM_ADDR, BASE);
    chk("arst_ready", 32'(bus.READY), 32'(0));
    bus.MEM_STB = 1'b1;
    @(negedge CLK);
    chk("arst_hold", 32'(bus.STATE), 32'(0));
    RST = 1'b0;
    chk("arst_writes", 32'(nwr), 32'd11);

    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    pixel(16'h0123, 8'h12, BASE);
    chk("total_writes", 32'(nwr), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
